// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, gain inverse, quadrant angles.
// Used by both vectoring and rotation mode CORDIC blocks.
package cordic_pkg;

  localparam int XW = 19;
  localparam int ZW = 32;
  localparam int MW = 18;

  localparam logic [15:0]   K_INV   = 16'd19898;
  localparam logic [ZW-1:0] ANG_90  = 32'h4000_0000;
  localparam logic [ZW-1:0] ANG_270 = 32'hC000_0000;

  typedef struct packed {
    logic          v;
    logic          zero;
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic [ZW-1:0] z;
  } vec_t;

  // atan(2^-i) scaled so a full circle is 2^32
  function automatic logic [ZW-1:0] atan_lut(input int i);
    case (i)
      0:       return 32'h2000_0000;
      1:       return 32'h12E4_051E;
      2:       return 32'h09FB_385B;
      3:       return 32'h0511_11D4;
      4:       return 32'h028B_0D43;
      5:       return 32'h0145_D7E1;
      6:       return 32'h00A2_F61E;
      7:       return 32'h0051_7C55;
      8:       return 32'h0028_BE53;
      9:       return 32'h0014_5F2F;
      10:      return 32'h000A_2F98;
      11:      return 32'h0005_17CC;
      12:      return 32'h0002_8BE6;
      13:      return 32'h0001_45F3;
      14:      return 32'h0000_A2FA;
      15:      return 32'h0000_517D;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered vectoring micro-rotation with fixed shift index IDX.
// Drives Y toward zero and accumulates the rotated angle in Z.
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic clock,
  input  logic reset_n,
  input  vec_t s_i,
  output vec_t s_o
);

  localparam logic [ZW-1:0] ANG = atan_lut(IDX);

  vec_t s_d, s_q;
  logic signed [XW-1:0] x, y, xs, ys;

  always_comb begin
    x   = s_i.x;
    y   = s_i.y;
    xs  = x >>> IDX;
    ys  = y >>> IDX;
    s_d = s_i;
    if (!y[XW-1]) begin
      s_d.x = x + ys;
      s_d.y = y - xs;
      s_d.z = s_i.z + ANG;
    end else begin
      s_d.x = x - ys;
      s_d.y = y + xs;
      s_d.z = s_i.z - ANG;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) s_q <= '0;
    else          s_q <= s_d;
  end

  assign s_o = s_q;

endmodule

// File: rtl/cordic_vectoring.sv
// Pipelined vectoring CORDIC: atan2 phase and magnitude of (Xin,Yin).
// Define CORDIC_VEC_GAIN_COMP_EN to scale mag by 1/K (one extra stage).
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int STG = 10
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic signed [15:0] Xin,
  input  logic signed [15:0] Yin,
  output logic               out_valid,
  output logic signed [31:0] phase,
  output logic        [17:0] mag
);

  vec_t pre_d, pre_q;
  vec_t pipe [STG+1];

  logic signed [XW-1:0] xe, ye;
  logic                 src_v;
  logic [ZW-1:0]        src_z;
  logic [MW-1:0]        src_m;
  logic                 out_valid_q;
  logic [ZW-1:0]        phase_q;
  logic [MW-1:0]        mag_q;
  logic                 unused_bits;

  // Fold left half-plane into the right half-plane
  always_comb begin
    xe         = {{(XW-16){Xin[15]}}, Xin};
    ye         = {{(XW-16){Yin[15]}}, Yin};
    pre_d      = '0;
    pre_d.v    = in_valid;
    pre_d.zero = (Xin == '0) && (Yin == '0);
    unique case (1'b1)
      !Xin[15]: begin
        pre_d.x = xe;
        pre_d.y = ye;
      end
      Xin[15] && !Yin[15]: begin
        pre_d.x = ye;
        pre_d.y = -xe;
        pre_d.z = ANG_90;
      end
      default: begin
        pre_d.x = -ye;
        pre_d.y = xe;
        pre_d.z = ANG_270;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) pre_q <= '0;
    else          pre_q <= pre_d;
  end

  assign pipe[0] = pre_q;

  for (genvar g = 0; g < STG; g++) begin : g_stg
    cordic_vec_stage #(
      .IDX(g)
    ) u_stg (
      .clock   (clock),
      .reset_n (reset_n),
      .s_i     (pipe[g]),
      .s_o     (pipe[g+1])
    );
  end

`ifdef CORDIC_VEC_GAIN_COMP_EN
  logic [33:0]   prod;
  logic          cv_q;
  logic [ZW-1:0] cz_q;
  logic [MW-1:0] cm_q;

  always_comb
    prod = 34'(pipe[STG].x[MW-1:0]) * 34'(K_INV) + 34'd16384;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cv_q <= 1'b0;
      cz_q <= '0;
      cm_q <= '0;
    end else begin
      cv_q <= pipe[STG].v;
      cz_q <= pipe[STG].zero ? '0 : pipe[STG].z;
      cm_q <= prod[15 +: MW];
    end
  end

  assign src_v = cv_q;
  assign src_z = cz_q;
  assign src_m = cm_q;
  assign unused_bits = ^{pipe[STG].y, pipe[STG].x[XW-1:MW],
                         prod[33], prod[14:0]};
`else
  assign src_v = pipe[STG].v;
  assign src_z = pipe[STG].zero ? '0 : pipe[STG].z;
  assign src_m = pipe[STG].x[MW-1:0];
  assign unused_bits = ^{pipe[STG].y, pipe[STG].x[XW-1:MW]};
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      phase_q     <= '0;
      mag_q       <= '0;
    end else begin
      out_valid_q <= src_v;
      if (src_v) begin
        phase_q <= src_z;
        mag_q   <= src_m;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign phase     = phase_q;
  assign mag       = mag_q;

endmodule
